adder_share_arbiter: RTL and testbench

//  Shares one WIDTH-bit adder (sum = a + b) between NUM_REQ requesters.

---
 rtl/adder_share_arbiter.sv | 119 +++++++++++
 tb/tb_adder_share_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one shared WIDTH-bit adder, round-robin granted among
// NUM_REQ valid/ready requesters, result held in a single tagged output register.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     cand;
    logic               any_valid;
    logic               slot_free;
    logic               load;
    logic [WIDTH-1:0]   op_a_p0;
    logic [WIDTH-1:0]   op_b_p0;
    logic [WIDTH:0]     sum_wide_p0;
    logic               vld_p1;
    logic [WIDTH-1:0]   sum_p1;
    logic               carry_p1;
    logic [IDW-1:0]     id_p1;

    // Full-width add keeping the carry-out as the top bit.
    function automatic logic [WIDTH:0] add_wide(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign any_valid = |req_valid;
    assign vld_p1    = (state_q == FULL);
    assign slot_free = !vld_p1 || rsp_ready;
    assign load      = slot_free && any_valid;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    // Grant is one-hot on the winner whenever the result slot can take a value.
    always_comb begin
        req_ready = '0;
        op_a_p0   = '0;
        op_b_p0   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                req_ready[i] = load;
                op_a_p0      = req_a[i*WIDTH +: WIDTH];
                op_b_p0      = req_b[i*WIDTH +: WIDTH];
            end
        end
        sum_wide_p0 = add_wide(op_a_p0, op_b_p0);
    end

    // Next-state logic for the output slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (any_valid) state_d = FULL;
            FULL:  if (rsp_ready && !any_valid) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Slot occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- stage p0 -> p1: capture granted sum, tag and advance the pointer ----
    // Result register and grant pointer load together on every transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p1     <= '0;
            carry_p1   <= 1'b0;
            id_p1      <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else if (load) begin
            sum_p1     <= sum_wide_p0[WIDTH-1:0];
            carry_p1   <= sum_wide_p0[WIDTH];
            id_p1      <= winner;
            last_grant <= winner;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_sum   = sum_p1;
    assign rsp_carry = carry_p1;
    assign rsp_id    = id_p1;
    assign busy      = vld_p1 || any_valid;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed table-driven bench for adder_share_arbiter (NUM_REQ=4, WIDTH=8).
module tb_adder_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic [1:0]  rsp_id;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic prev_vld = 1'b0;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  rdy;
        logic        vld;
        logic        chk;
        logic [7:0]  sum;
        logic        c;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] OPA = 32'h40302010;
    localparam logic [31:0] OPB = 32'h04030201;

    adder_share_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [3:0] v, logic [31:0] a, logic [31:0] b, logic rr,
                                logic [3:0] rdy, logic vld, logic chk, logic [7:0] sum,
                                logic c, logic [1:0] id);
        vec_t t;
        t.v = v; t.a = a; t.b = b; t.rr = rr; t.rdy = rdy;
        t.vld = vld; t.chk = chk; t.sum = sum; t.c = c; t.id = id;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t t);
        req_valid = t.v;
        req_a     = t.a;
        req_b     = t.b;
        rsp_ready = t.rr;
        #1;
        chk("req_ready", 32'(req_ready), 32'(t.rdy));
        chk("busy", 32'(busy), 32'(prev_vld | (|t.v)));
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(t.vld));
        if (t.chk) begin
            chk("rsp_sum", 32'(rsp_sum), 32'(t.sum));
            chk("rsp_carry", 32'(rsp_carry), 32'(t.c));
            chk("rsp_id", 32'(rsp_id), 32'(t.id));
        end
        prev_vld = t.vld;
    endtask

    initial begin
        // basic add, then overflow cases
        tbl.push_back(mk(4'b0001, 32'h00000012, 32'h00000034, 1, 4'b0001, 1, 1, 8'h46, 0, 0));
        tbl.push_back(mk(4'b0010, 32'h0000FF00, 32'h00000100, 1, 4'b0010, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(4'b0100, 32'h00800000, 32'h00800000, 1, 4'b0100, 1, 1, 8'h00, 1, 2));
        // sparse with last_grant=2: wrap to 0, then 1
        tbl.push_back(mk(4'b0011, 32'h00001005, 32'h00002003, 1, 4'b0001, 1, 1, 8'h08, 0, 0));
        tbl.push_back(mk(4'b0011, 32'h00001005, 32'h00002003, 1, 4'b0010, 1, 1, 8'h30, 0, 1));
        // drain to empty, then grant 3 to set the pointer to 3
        tbl.push_back(mk(4'b0000, OPA, OPB, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(4'b1000, OPA, OPB, 1, 4'b1000, 1, 1, 8'h44, 0, 3));
        // all valid: grants 0,1,2,3,0,1
        tbl.push_back(mk(4'b1111, OPA, OPB, 1, 4'b0001, 1, 1, 8'h11, 0, 0));
        tbl.push_back(mk(4'b1111, OPA, OPB, 1, 4'b0010, 1, 1, 8'h22, 0, 1));
        tbl.push_back(mk(4'b1111, OPA, OPB, 1, 4'b0100, 1, 1, 8'h33, 0, 2));
        tbl.push_back(mk(4'b1111, OPA, OPB, 1, 4'b1000, 1, 1, 8'h44, 0, 3));
        tbl.push_back(mk(4'b1111, OPA, OPB, 1, 4'b0001, 1, 1, 8'h11, 0, 0));
        tbl.push_back(mk(4'b1111, OPA, OPB, 1, 4'b0010, 1, 1, 8'h22, 0, 1));
        // backpressure 3 cycles, then same-cycle reload with next winner (2)
        tbl.push_back(mk(4'b1111, OPA, OPB, 0, 4'b0000, 1, 1, 8'h22, 0, 1));
        tbl.push_back(mk(4'b1111, OPA, OPB, 0, 4'b0000, 1, 1, 8'h22, 0, 1));
        tbl.push_back(mk(4'b1111, OPA, OPB, 0, 4'b0000, 1, 1, 8'h22, 0, 1));
        tbl.push_back(mk(4'b1111, OPA, OPB, 1, 4'b0100, 1, 1, 8'h33, 0, 2));
        // requester 3 drops valid before grant: no result, pointer stays at 2
        tbl.push_back(mk(4'b1000, OPA, OPB, 0, 4'b0000, 1, 1, 8'h33, 0, 2));
        tbl.push_back(mk(4'b0000, OPA, OPB, 1, 4'b0000, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(4'b1001, OPA, OPB, 1, 4'b1000, 1, 1, 8'h44, 0, 3));

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_sum", 32'(rsp_sum), 32'd0);
        chk("reset rsp_carry", 32'(rsp_carry), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i]);

        // Reset pulse while FULL with requests pending
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-rst rsp_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async rst rsp_sum", 32'(rsp_sum), 32'd0);
        chk("async rst rsp_id", 32'(rsp_id), 32'd0);
        chk("async rst rsp_carry", 32'(rsp_carry), 32'd0);
        @(posedge clk);
        #1;
        chk("held rst rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        prev_vld = 1'b0;
        // pointer back at 3: lowest valid index (1) wins
        step(mk(4'b0110, OPA, OPB, 1, 4'b0010, 1, 1, 8'h22, 0, 1));
        step(mk(4'b0000, OPA, OPB, 1, 4'b0000, 0, 0, 8'h00, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
